input_ctrl: RTL



---
 rtl/game_types.sv | 19 +
 rtl/debounce_sync.sv | 49 ++++
 rtl/input_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/game_types.sv
`default_nettype none
// +------------------------------------------------------------------+
// | game_types : shared key indices and KEY[3] hold-FSM state type    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package game_types;

  localparam int KEY_CONFIRM = 0;
  localparam int KEY_RANDOM  = 1;
  localparam int KEY_BACK    = 3;

  typedef enum logic [1:0] {
    H_IDLE    = 2'd0,
    H_HELD    = 2'd1,
    H_LATCHED = 2'd2
  } hold_state_t;

endpackage
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | debounce_sync : 2-flop synchronizer followed by a stable-time     |
// | debouncer for one asynchronous input.                             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module debounce_sync #(
  parameter int DB_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic RESET_VAL,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= RESET_VAL;
      r_sync   <= RESET_VAL;
      r_stable <= RESET_VAL;
      r_cnt    <= '0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        // The synced value has differed for DB_CYCLES samples in a row.
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout = r_stable;

endmodule
`default_nettype wire

// File: rtl/input_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | input_ctrl : synchronizes/debounces SW and KEY, decodes the       |
// | candidate digit and emits single-cycle game command pulses.       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module input_ctrl
  import game_types::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int HOLD_MS     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] SW,
  input  logic [3:0] KEY,
  output logic [3:0] candidate,
  output logic       sw_valid,
  output logic       confirm_p,
  output logic       confirm_err_p,
  output logic       random_p,
  output logic       back_p,
  output logic       restart_p
);

  localparam int DB_RAW      = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DB_CYCLES   = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int HOLD_RAW    = CLK_HZ / 1000 * HOLD_MS;
  localparam int HOLD_CYCLES = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
  localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYCLES - 1);

  logic [9:0] w_sw_db;
  logic [3:0] w_key_db;
  logic [3:0] r_key_d;
  logic [3:0] w_press;
  logic       w_unused_key2;

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_sw_db
      debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk       (clk),
        .rst       (rst),
        .RESET_VAL (1'b0),
        .din       (SW[gi]),
        .dout      (w_sw_db[gi])
      );
    end
    for (genvar gk = 0; gk < 4; gk++) begin : g_key_db
      debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk       (clk),
        .rst       (rst),
        .RESET_VAL (1'b1),
        .din       (KEY[gk]),
        .dout      (w_key_db[gk])
      );
    end
  endgenerate

  // Keys are active-low: a press is a debounced 1 -> 0 transition.
  assign w_press       = r_key_d & ~w_key_db;
  assign w_unused_key2 = w_press[2];

  logic       w_onehot;
  logic [3:0] w_idx;
  logic [3:0] w_pop;

  always_comb begin
    w_pop = '0;
    w_idx = '0;
    for (int i = 0; i < 10; i++) begin
      if (w_sw_db[i]) begin
        w_pop = w_pop + 4'd1;
        w_idx = 4'(i);
      end
    end
    w_onehot = (w_pop == 4'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_d       <= 4'hF;
      sw_valid      <= 1'b0;
      candidate     <= '0;
      confirm_p     <= 1'b0;
      confirm_err_p <= 1'b0;
      random_p      <= 1'b0;
    end else begin
      r_key_d       <= w_key_db;
      sw_valid      <= w_onehot;
      candidate     <= w_onehot ? w_idx : 4'd0;
      random_p      <= w_press[KEY_RANDOM];
      // A simultaneous random request suppresses either confirm outcome.
      confirm_p     <= w_press[KEY_CONFIRM] & ~w_press[KEY_RANDOM] & sw_valid;
      confirm_err_p <= w_press[KEY_CONFIRM] & ~w_press[KEY_RANDOM] & ~sw_valid;
    end
  end

  hold_state_t       r_hold_state;
  hold_state_t       w_hold_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_next;
  logic              w_back_next;
  logic              w_restart_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_state <= H_IDLE;
      r_hold_cnt   <= '0;
      back_p       <= 1'b0;
      restart_p    <= 1'b0;
    end else begin
      r_hold_state <= w_hold_next;
      r_hold_cnt   <= w_hold_cnt_next;
      back_p       <= w_back_next;
      restart_p    <= w_restart_next;
    end
  end

  always_comb begin
    w_hold_next     = r_hold_state;
    w_hold_cnt_next = r_hold_cnt;
    w_back_next     = 1'b0;
    w_restart_next  = 1'b0;
    case (r_hold_state)
      H_IDLE: begin
        if (w_press[KEY_BACK]) begin
          w_hold_next     = H_HELD;
          w_hold_cnt_next = '0;
        end
      end
      H_HELD: begin
        if (r_hold_cnt == c_hold_last) begin
          w_restart_next = 1'b1;
          w_hold_next    = H_LATCHED;
        end else if (w_key_db[KEY_BACK]) begin
          w_back_next = 1'b1;
          w_hold_next = H_IDLE;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      H_LATCHED: begin
        if (w_key_db[KEY_BACK]) w_hold_next = H_IDLE;
      end
      default: w_hold_next = H_IDLE;
    endcase
  end

endmodule
`default_nettype wire
